// File: rtl/prf_mp_pkg.sv
// Shared PRF definitions so dispatch, issue and complete agree on tag width and port counts.
package prf_mp_pkg;

  localparam int NUM_PREGS = 64;
  localparam int DATA_W    = 32;
  localparam int NUM_RD    = 4;
  localparam int NUM_WR    = 2;
  localparam int NUM_AL    = 2;
  localparam int TAG_W     = $clog2(NUM_PREGS);

  typedef logic [TAG_W-1:0] preg_tag_t;

endpackage

// File: rtl/prf_mp_rdport.sv
// One PRF read port: zero-tag mux, ready lookup and, when PRF_MP_BYPASS_EN is
// defined, a same-cycle writeback bypass where the highest matching write port wins.
module prf_mp_rdport
  import prf_mp_pkg::*;
#(
  parameter int NUM_PREGS = prf_mp_pkg::NUM_PREGS,
  parameter int DATA_W    = prf_mp_pkg::DATA_W,
`ifdef PRF_MP_BYPASS_EN
  parameter int NUM_WR    = prf_mp_pkg::NUM_WR,
`endif
  parameter int TAG_W     = $clog2(NUM_PREGS)
) (
  input  logic [TAG_W-1:0]         rd_tag,
  input  logic [DATA_W-1:0]        regs [NUM_PREGS],
  input  logic [NUM_PREGS-1:0]     ready,
`ifdef PRF_MP_BYPASS_EN
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*TAG_W-1:0]  wr_tag,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
`endif
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_ready
);

  always_comb begin
    rd_data  = '0;
    rd_ready = 1'b1;
    if (rd_tag != '0) begin
      rd_data  = regs[rd_tag];
      rd_ready = ready[rd_tag];
`ifdef PRF_MP_BYPASS_EN
      // Later ports override earlier ones; the in-flight write also reports ready.
      for (int i = 0; i < NUM_WR; i++) begin
        if (wr_en[i] && (wr_tag[i*TAG_W +: TAG_W] == rd_tag)) begin
          rd_data  = wr_data[i*DATA_W +: DATA_W];
          rd_ready = 1'b1;
        end
      end
`endif
    end
  end

endmodule

// File: rtl/prf_mp.sv
// Multi-ported physical register file with a per-register ready scoreboard.
// Optional same-cycle write-to-read bypass is enabled by defining PRF_MP_BYPASS_EN.
module prf_mp
  import prf_mp_pkg::*;
#(
  parameter int   NUM_PREGS = prf_mp_pkg::NUM_PREGS,
  parameter int   DATA_W    = prf_mp_pkg::DATA_W,
  parameter int   NUM_RD    = prf_mp_pkg::NUM_RD,
  parameter int   NUM_WR    = prf_mp_pkg::NUM_WR,
  parameter int   NUM_AL    = prf_mp_pkg::NUM_AL,
  localparam int  TAG_W     = $clog2(NUM_PREGS)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_RD*TAG_W-1:0]  rd_tag,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_ready,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*TAG_W-1:0]  wr_tag,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic [NUM_AL-1:0]        al_en,
  input  logic [NUM_AL*TAG_W-1:0]  al_tag,
  output logic                     wr_conflict
);

  logic [DATA_W-1:0]    regs_q [NUM_PREGS];
  logic [DATA_W-1:0]    regs_d [NUM_PREGS];
  logic [NUM_PREGS-1:0] ready_q;
  logic [NUM_PREGS-1:0] ready_d;
  logic                 wr_conflict_q;
  logic                 wr_conflict_d;

  // Writes first (higher port wins data), then allocations so they win the ready bit.
  always_comb begin
    regs_d  = regs_q;
    ready_d = ready_q;
    for (int i = 0; i < NUM_WR; i++) begin
      if (wr_en[i] && (wr_tag[i*TAG_W +: TAG_W] != '0)) begin
        regs_d[wr_tag[i*TAG_W +: TAG_W]]  = wr_data[i*DATA_W +: DATA_W];
        ready_d[wr_tag[i*TAG_W +: TAG_W]] = 1'b1;
      end
    end
    for (int a = 0; a < NUM_AL; a++) begin
      if (al_en[a] && (al_tag[a*TAG_W +: TAG_W] != '0)) begin
        ready_d[al_tag[a*TAG_W +: TAG_W]] = 1'b0;
      end
    end
  end

  always_comb begin
    wr_conflict_d = 1'b0;
    for (int i = 0; i < NUM_WR; i++) begin
      for (int j = i + 1; j < NUM_WR; j++) begin
        if (wr_en[i] && wr_en[j] &&
            (wr_tag[i*TAG_W +: TAG_W] == wr_tag[j*TAG_W +: TAG_W]) &&
            (wr_tag[i*TAG_W +: TAG_W] != '0)) begin
          wr_conflict_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < NUM_PREGS; k++) begin
        regs_q[k] <= '0;
      end
      ready_q       <= '1;
      wr_conflict_q <= 1'b0;
    end else begin
      regs_q        <= regs_d;
      ready_q       <= ready_d;
      wr_conflict_q <= wr_conflict_d;
    end
  end

  assign wr_conflict = wr_conflict_q;

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rdport
    prf_mp_rdport #(
      .NUM_PREGS (NUM_PREGS),
      .DATA_W    (DATA_W),
`ifdef PRF_MP_BYPASS_EN
      .NUM_WR    (NUM_WR),
`endif
      .TAG_W     (TAG_W)
    ) u_rdport (
      .rd_tag   (rd_tag[p*TAG_W +: TAG_W]),
      .regs     (regs_q),
      .ready    (ready_q),
`ifdef PRF_MP_BYPASS_EN
      .wr_en    (wr_en),
      .wr_tag   (wr_tag),
      .wr_data  (wr_data),
`endif
      .rd_data  (rd_data[p*DATA_W +: DATA_W]),
      .rd_ready (rd_ready[p])
    );
  end

endmodule

// File: tb/tb_prf_mp.sv
// Directed self-checking bench for prf_mp with hand-computed expected values.
// Covers reset, allocate/write scoreboard, write conflicts, tag 0 and mid-run reset.
module tb_prf_mp;

  localparam int NUM_PREGS = 64;
  localparam int DATA_W    = 32;
  localparam int NUM_RD    = 4;
  localparam int NUM_WR    = 2;
  localparam int NUM_AL    = 2;
  localparam int TAG_W     = 6;

  logic                     clock = 1'b0;
  logic                     reset;
  logic [NUM_RD*TAG_W-1:0]  rd_tag;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_ready;
  logic [NUM_WR-1:0]        wr_en;
  logic [NUM_WR*TAG_W-1:0]  wr_tag;
  logic [NUM_WR*DATA_W-1:0] wr_data;
  logic [NUM_AL-1:0]        al_en;
  logic [NUM_AL*TAG_W-1:0]  al_tag;
  logic                     wr_conflict;

  int num_vectors    = 0;
  int num_miscompares = 0;

  prf_mp dut (
    .clock       (clock),
    .reset       (reset),
    .rd_tag      (rd_tag),
    .rd_data     (rd_data),
    .rd_ready    (rd_ready),
    .wr_en       (wr_en),
    .wr_tag      (wr_tag),
    .wr_data     (wr_data),
    .al_en       (al_en),
    .al_tag      (al_tag),
    .wr_conflict (wr_conflict)
  );

  always #50 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    num_vectors++;
    if (actual !== expected) begin
      num_miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] we, input logic [5:0] wt0, input logic [5:0] wt1,
                               input logic [31:0] wd0, input logic [31:0] wd1,
                               input logic [1:0] ae, input logic [5:0] at0, input logic [5:0] at1);
    wr_en   = we;
    wr_tag  = {wt1, wt0};
    wr_data = {wd1, wd0};
    al_en   = ae;
    al_tag  = {at1, at0};
  endtask

  task automatic idle();
    applyStimulus(2'b00, 6'd0, 6'd0, 32'h0, 32'h0, 2'b00, 6'd0, 6'd0);
  endtask

  task automatic checkRead(input string name, input int port, input logic [5:0] tag,
                           input logic [31:0] exp_data, input logic exp_ready);
    rd_tag[port*TAG_W +: TAG_W] = tag;
    #1;
    checkOutput({name, "_data"}, rd_data[port*DATA_W +: DATA_W], exp_data);
    checkOutput({name, "_ready"}, {31'b0, rd_ready[port]}, {31'b0, exp_ready});
  endtask

  task automatic checkConflict(input string name, input logic expected);
    checkOutput(name, {31'b0, wr_conflict}, {31'b0, expected});
  endtask

  initial begin
    logic [5:0] reset_tags [3];
    logic [5:0] cleared_tags [6];
    reset_tags   = '{6'd0, 6'd1, 6'd63};
    cleared_tags = '{6'd3, 6'd7, 6'd20, 6'd9, 6'd5, 6'd12};

    reset  = 1'b1;
    rd_tag = '0;
    idle();
    tick();
    tick();
    reset = 1'b0;

    // Reset state on every port
    foreach (reset_tags[k]) begin
      for (int p = 0; p < NUM_RD; p++) begin
        checkRead($sformatf("rst_t%0d_p%0d", reset_tags[k], p), p, reset_tags[k], 32'h0, 1'b1);
      end
    end
    checkConflict("rst_conflict", 1'b0);

    // Allocate tag 5 at t, write it at t+3
    applyStimulus(2'b00, 6'd0, 6'd0, 32'h0, 32'h0, 2'b01, 6'd5, 6'd0);
    tick();
    idle();
    checkRead("alloc5_t1", 0, 6'd5, 32'h0, 1'b0);
    tick();
    checkRead("alloc5_t2", 1, 6'd5, 32'h0, 1'b0);
    tick();
    applyStimulus(2'b10, 6'd0, 6'd5, 32'h0, 32'hDEADBEEF, 2'b00, 6'd0, 6'd0);
`ifdef PRF_MP_BYPASS_EN
    checkRead("alloc5_t3_bypass", 2, 6'd5, 32'hDEADBEEF, 1'b1);
`else
    checkRead("alloc5_t3", 2, 6'd5, 32'h0, 1'b0);
`endif
    tick();
    idle();
    checkRead("alloc5_t4", 3, 6'd5, 32'hDEADBEEF, 1'b1);

    // Two writes to tag 9: port 1 wins, conflict for one cycle
    applyStimulus(2'b11, 6'd9, 6'd9, 32'h11, 32'h22, 2'b00, 6'd0, 6'd0);
    tick();
    idle();
    checkRead("dup9_data", 0, 6'd9, 32'h22, 1'b1);
    checkConflict("dup9_conflict_set", 1'b1);
    checkRead("dup9_keep5", 1, 6'd5, 32'hDEADBEEF, 1'b1);
    tick();
    checkConflict("dup9_conflict_clr", 1'b0);
    checkRead("dup9_hold", 0, 6'd9, 32'h22, 1'b1);

    // Distinct tags never conflict
    applyStimulus(2'b11, 6'd10, 6'd11, 32'hA1, 32'hB2, 2'b00, 6'd0, 6'd0);
    tick();
    idle();
    checkConflict("distinct_conflict", 1'b0);
    checkRead("distinct10", 0, 6'd10, 32'hA1, 1'b1);
    checkRead("distinct11", 1, 6'd11, 32'hB2, 1'b1);

    // Two writes to tag 0 are ignored entirely
    applyStimulus(2'b11, 6'd0, 6'd0, 32'h5, 32'h6, 2'b00, 6'd0, 6'd0);
    tick();
    idle();
    checkConflict("zero_dup_conflict", 1'b0);

    // Allocate and write tag 12 together: data lands, ready stays low
    applyStimulus(2'b01, 6'd12, 6'd0, 32'h77, 32'h0, 2'b01, 6'd12, 6'd0);
    tick();
    idle();
    checkRead("alwr12", 2, 6'd12, 32'h77, 1'b0);

    // Double allocation of tag 11 keeps data, clears ready
    applyStimulus(2'b00, 6'd0, 6'd0, 32'h0, 32'h0, 2'b11, 6'd11, 6'd11);
    tick();
    idle();
    checkRead("dupal11", 3, 6'd11, 32'hB2, 1'b0);

    // Tag 0 is hardwired
    applyStimulus(2'b01, 6'd0, 6'd0, 32'hFFFF, 32'h0, 2'b01, 6'd0, 6'd0);
    tick();
    idle();
    checkRead("tag0", 0, 6'd0, 32'h0, 1'b1);

    // Mid-run reset drops concurrent writes/allocations
    applyStimulus(2'b11, 6'd3, 6'd7, 32'hAAAA, 32'hBBBB, 2'b00, 6'd0, 6'd0);
    tick();
    applyStimulus(2'b00, 6'd0, 6'd0, 32'h0, 32'h0, 2'b01, 6'd20, 6'd0);
    tick();
    idle();
    checkRead("pre_rst3", 0, 6'd3, 32'hAAAA, 1'b1);
    checkRead("pre_rst20", 1, 6'd20, 32'h0, 1'b0);
    reset = 1'b1;
    applyStimulus(2'b11, 6'd3, 6'd3, 32'h1234, 32'h5678, 2'b11, 6'd7, 6'd20);
    tick();
    reset = 1'b0;
    idle();
    foreach (cleared_tags[k]) begin
      checkRead($sformatf("post_rst_t%0d", cleared_tags[k]), k % NUM_RD, cleared_tags[k], 32'h0, 1'b1);
    end
    checkConflict("post_rst_conflict", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", num_vectors, num_miscompares);
    $finish;
  end

endmodule
